// File: rtl/dict_boot_sequencer_pkg.sv
// Shared constants, state encoding and count helpers for the dictionary boot sequencer.
package dict_boot_sequencer_pkg;

    localparam int          DEF_FIELD1_KEY_WIDTH = 3;
    localparam int          DEF_FIELD2_KEY_WIDTH = 5;
    localparam int          DEF_FIELD3_KEY_WIDTH = 8;
    localparam int          DEF_FIELD1_VAL_WIDTH = 7;
    localparam int          DEF_FIELD2_VAL_WIDTH = 10;
    localparam int          DEF_FIELD3_VAL_WIDTH = 15;
    localparam logic [31:0] DEF_DICT_BASE        = 32'h0000_1000;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    // Counts are 9 bits so a full 256-entry dictionary is representable.
    localparam int CNT_W = 9;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_LOAD1 = 3'd1,
        ST_LOAD2 = 3'd2,
        ST_LOAD3 = 3'd3,
        ST_DONE  = 3'd4
    } boot_state_e;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [7:0] n, input logic [CNT_W-1:0] cap);
        return ({1'b0, n} > cap) ? cap : {1'b0, n};
    endfunction

    function automatic logic over_cap(input logic [7:0] n, input logic [CNT_W-1:0] cap);
        return {1'b0, n} > cap;
    endfunction

    // First phase that still has words to load; empty phases are skipped.
    function automatic boot_state_e first_phase(input logic has1, input logic has2, input logic has3);
        if (has1)      return ST_LOAD1;
        else if (has2) return ST_LOAD2;
        else if (has3) return ST_LOAD3;
        else           return ST_DONE;
    endfunction

endpackage

// File: rtl/dict_boot_sequencer_mem_port_mux.sv
// Steers the memory port between the boot sequencer and the controller; the controller side is
// held quiet (ready=0, rdata=0) until boot completes.
module dict_boot_sequencer_mem_port_mux (
    input  logic        sel_ctrl,
    input  logic        seq_valid,
    input  logic [31:0] seq_addr,
    output logic        seq_ready,
    input  logic        ctrl_valid,
    input  logic [31:0] ctrl_addr,
    output logic        ctrl_ready,
    output logic [31:0] ctrl_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    assign mem_valid  = sel_ctrl ? ctrl_valid : seq_valid;
    assign mem_addr   = sel_ctrl ? ctrl_addr  : seq_addr;
    assign seq_ready  = ~sel_ctrl & mem_ready;
    assign ctrl_ready = sel_ctrl & mem_ready;
    assign ctrl_rdata = sel_ctrl ? mem_rdata : 32'h0;

endmodule

// File: rtl/dict_boot_sequencer.sv
// Loads the three compression dictionaries from a header-prefixed memory image after reset,
// then hands the memory port to the controller.
module dict_boot_sequencer
    import dict_boot_sequencer_pkg::*;
#(
    parameter int          FIELD1_KEY_WIDTH = DEF_FIELD1_KEY_WIDTH,
    parameter int          FIELD2_KEY_WIDTH = DEF_FIELD2_KEY_WIDTH,
    parameter int          FIELD3_KEY_WIDTH = DEF_FIELD3_KEY_WIDTH,
    parameter int          FIELD1_VAL_WIDTH = DEF_FIELD1_VAL_WIDTH,
    parameter int          FIELD2_VAL_WIDTH = DEF_FIELD2_VAL_WIDTH,
    parameter int          FIELD3_VAL_WIDTH = DEF_FIELD3_VAL_WIDTH,
    parameter logic [31:0] DICT_BASE        = DEF_DICT_BASE,
    parameter bit          LOAD_ON_RESET    = 1'b1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        ctrl_req_valid,
    output logic                        ctrl_req_ready,
    input  logic [ADDR_W-1:0]           ctrl_req_addr,
    output logic [31:0]                 ctrl_req_rdata,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_W-1:0]           mem_req_addr,
    input  logic [31:0]                 mem_req_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
    output logic                        boot_done,
    output logic                        boot_err,
    output boot_state_e                 state_dbg
);

    localparam logic [CNT_W-1:0] CAP1 = CNT_W'(1 << FIELD1_KEY_WIDTH);
    localparam logic [CNT_W-1:0] CAP2 = CNT_W'(1 << FIELD2_KEY_WIDTH);
    localparam logic [CNT_W-1:0] CAP3 = CNT_W'(1 << FIELD3_KEY_WIDTH);

    // Handshake: a word moves in the cycle where valid and ready are both high; rdata is taken in
    // that cycle. The sequencer drops valid for one cycle after every transfer, so ready may be
    // held high without causing a double fetch.

    boot_state_e       state;
    logic              seq_valid;
    logic [ADDR_W-1:0] seq_addr;
    logic              seq_ready;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  cnt1, cnt2, cnt3;

    logic              xfer;
    logic [CNT_W-1:0]  hdr_c1, hdr_c2, hdr_c3;
    logic              hdr_over;
    logic [CNT_W-1:0]  cur_cnt;
    logic              last_word;
    boot_state_e       phase_next;

    dict_boot_sequencer_mem_port_mux u_mux (
        .sel_ctrl   (boot_done),
        .seq_valid  (seq_valid),
        .seq_addr   (seq_addr),
        .seq_ready  (seq_ready),
        .ctrl_valid (ctrl_req_valid),
        .ctrl_addr  (ctrl_req_addr),
        .ctrl_ready (ctrl_req_ready),
        .ctrl_rdata (ctrl_req_rdata),
        .mem_valid  (mem_req_valid),
        .mem_addr   (mem_req_addr),
        .mem_ready  (mem_req_ready),
        .mem_rdata  (mem_req_rdata)
    );

    assign xfer      = seq_valid & seq_ready & (state != ST_DONE);
    assign state_dbg = state;

    assign hdr_c1   = clamp_count(mem_req_rdata[7:0],   CAP1);
    assign hdr_c2   = clamp_count(mem_req_rdata[15:8],  CAP2);
    assign hdr_c3   = clamp_count(mem_req_rdata[23:16], CAP3);
    assign hdr_over = over_cap(mem_req_rdata[7:0],   CAP1) |
                      over_cap(mem_req_rdata[15:8],  CAP2) |
                      over_cap(mem_req_rdata[23:16], CAP3);

    always_comb begin
        cur_cnt    = '0;
        phase_next = ST_DONE;
        case (state)
            ST_HDR: begin
                phase_next = first_phase(hdr_c1 != '0, hdr_c2 != '0, hdr_c3 != '0);
            end
            ST_LOAD1: begin
                cur_cnt    = cnt1;
                phase_next = first_phase(1'b0, cnt2 != '0, cnt3 != '0);
            end
            ST_LOAD2: begin
                cur_cnt    = cnt2;
                phase_next = first_phase(1'b0, 1'b0, cnt3 != '0);
            end
            ST_LOAD3: begin
                cur_cnt    = cnt3;
                phase_next = ST_DONE;
            end
            default: begin
                cur_cnt    = '0;
                phase_next = ST_DONE;
            end
        endcase
    end

    assign last_word = (cur_cnt != '0) && (word_cnt == cur_cnt - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state              <= LOAD_ON_RESET ? ST_HDR : ST_DONE;
            seq_valid          <= 1'b0;
            seq_addr           <= DICT_BASE;
            word_cnt           <= '0;
            cnt1               <= '0;
            cnt2               <= '0;
            cnt3               <= '0;
            dict1_write_enable <= 1'b0;
            dict1_write_val    <= '0;
            dict2_write_enable <= 1'b0;
            dict2_write_val    <= '0;
            dict3_write_enable <= 1'b0;
            dict3_write_val    <= '0;
            boot_done          <= 1'b0;
            boot_err           <= 1'b0;
        end else begin
            dict1_write_enable <= 1'b0;
            dict2_write_enable <= 1'b0;
            dict3_write_enable <= 1'b0;

            if (xfer) begin
                seq_valid <= 1'b0;
                seq_addr  <= seq_addr + ADDR_STEP;
            end else begin
                seq_valid <= (state != ST_DONE);
            end

            case (state)
                ST_HDR: begin
                    if (xfer) begin
                        cnt1     <= hdr_c1;
                        cnt2     <= hdr_c2;
                        cnt3     <= hdr_c3;
                        boot_err <= hdr_over;
                    end
                end
                ST_LOAD1: begin
                    if (xfer) begin
                        dict1_write_enable <= 1'b1;
                        dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                    end
                end
                ST_LOAD2: begin
                    if (xfer) begin
                        dict2_write_enable <= 1'b1;
                        dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                    end
                end
                ST_LOAD3: begin
                    if (xfer) begin
                        dict3_write_enable <= 1'b1;
                        dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                    end
                end
                default: begin
                    boot_done <= 1'b1;
                end
            endcase

            // Phase advance: the header always moves on; a load phase moves on after its last word.
            if (xfer) begin
                if (state == ST_HDR || last_word) begin
                    state    <= phase_next;
                    word_cnt <= '0;
                    if (phase_next == ST_DONE) begin
                        boot_done <= 1'b1;
                    end
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dict_boot_sequencer.sv
// Bench for dict_boot_sequencer: random memory images and latencies checked against a
// queue-based model of the expected fetch order and dictionary contents.
module tb_dict_boot_sequencer;
    import dict_boot_sequencer_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        ctrl_req_valid, ctrl_req_ready;
    logic [31:0] ctrl_req_addr, ctrl_req_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_rdata;
    logic        d1_we, d2_we, d3_we;
    logic [6:0]  d1_val;
    logic [9:0]  d2_val;
    logic [14:0] d3_val;
    logic        boot_done, boot_err;
    boot_state_e state_dbg;

    logic        nl_ctrl_valid, nl_ctrl_ready;
    logic [31:0] nl_ctrl_addr, nl_ctrl_rdata;
    logic        nl_mem_valid, nl_mem_ready;
    logic [31:0] nl_mem_addr, nl_mem_rdata;
    logic        nl_d1_we, nl_d2_we, nl_d3_we;
    logic [6:0]  nl_d1_val;
    logic [9:0]  nl_d2_val;
    logic [14:0] nl_d3_val;
    logic        nl_boot_done, nl_boot_err;
    boot_state_e nl_state_dbg;

    dict_boot_sequencer dut (
        .clk(clk), .resetn(resetn),
        .ctrl_req_valid(ctrl_req_valid), .ctrl_req_ready(ctrl_req_ready),
        .ctrl_req_addr(ctrl_req_addr), .ctrl_req_rdata(ctrl_req_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
        .dict1_write_enable(d1_we), .dict1_write_val(d1_val),
        .dict2_write_enable(d2_we), .dict2_write_val(d2_val),
        .dict3_write_enable(d3_we), .dict3_write_val(d3_val),
        .boot_done(boot_done), .boot_err(boot_err), .state_dbg(state_dbg)
    );

    dict_boot_sequencer #(.LOAD_ON_RESET(1'b0)) dut_nl (
        .clk(clk), .resetn(resetn),
        .ctrl_req_valid(nl_ctrl_valid), .ctrl_req_ready(nl_ctrl_ready),
        .ctrl_req_addr(nl_ctrl_addr), .ctrl_req_rdata(nl_ctrl_rdata),
        .mem_req_valid(nl_mem_valid), .mem_req_ready(nl_mem_ready),
        .mem_req_addr(nl_mem_addr), .mem_req_rdata(nl_mem_rdata),
        .dict1_write_enable(nl_d1_we), .dict1_write_val(nl_d1_val),
        .dict2_write_enable(nl_d2_we), .dict2_write_val(nl_d2_val),
        .dict3_write_enable(nl_d3_we), .dict3_write_val(nl_d3_val),
        .boot_done(nl_boot_done), .boot_err(nl_boot_err), .state_dbg(nl_state_dbg)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_q[$];
    logic [6:0]  exp1[$];
    logic [9:0]  exp2[$];
    logic [14:0] exp3[$];
    logic        exp_err;
    logic [31:0] fetch_q[$];
    logic [6:0]  got1[$];
    logic [9:0]  got2[$];
    logic [14:0] got3[$];

    int cyc = 0;
    int last_xfer_cyc = -1, done_cyc = -1, last_wr_cyc = -1;
    int lat_min = 1, lat_max = 1, lat_cur = 1, wait_cnt = 0;
    int xfer_age = 0;
    int viol_gap = 0, viol_ctrl = 0, viol_onehot = 0, viol_nl = 0;

    function automatic logic [31:0] get_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder and output monitor; inputs change only here on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (nl_mem_valid !== 1'b0) viol_nl++;
        if (int'(d1_we) + int'(d2_we) + int'(d3_we) > 1) viol_onehot++;
        if (d1_we) begin got1.push_back(d1_val); last_wr_cyc = cyc; end
        if (d2_we) begin got2.push_back(d2_val); last_wr_cyc = cyc; end
        if (d3_we) begin got3.push_back(d3_val); last_wr_cyc = cyc; end
        if (boot_done && done_cyc < 0) done_cyc = cyc;
        if (!boot_done && (ctrl_req_ready !== 1'b0 || ctrl_req_rdata !== 32'h0)) viol_ctrl++;

        if (xfer_age == 1) begin
            if (resetn && !boot_done && mem_req_valid !== 1'b0) viol_gap++;
            xfer_age = 2;
        end else if (xfer_age == 2) begin
            if (resetn && !boot_done && mem_req_valid !== 1'b1) viol_gap++;
            xfer_age = 0;
        end

        if (!resetn) begin
            mem_req_ready = 1'b0;
            mem_req_rdata = $urandom;
            wait_cnt = 0;
        end else if (mem_req_valid) begin
            if (wait_cnt >= lat_cur) begin
                mem_req_ready = 1'b1;
                mem_req_rdata = get_word(mem_req_addr);
                wait_cnt = 0;
                lat_cur = $urandom_range(lat_max, lat_min);
                if (!boot_done) begin
                    fetch_q.push_back(mem_req_addr);
                    last_xfer_cyc = cyc;
                    xfer_age = 1;
                end
            end else begin
                mem_req_ready = 1'b0;
                mem_req_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            mem_req_ready = 1'b0;
            mem_req_rdata = $urandom;
            wait_cnt = 0;
        end
    end

    // Reference model: image contents and clamped counts give fetch order and dictionary contents.
    task automatic setup_image(input int n1, input int n2, input int n3);
        int c1, c2, c3;
        logic [7:0] b1, b2, b3;
        b1 = 8'(n1); b2 = 8'(n2); b3 = 8'(n3);
        mem.delete();
        mem[32'h1000] = {8'h00, b3, b2, b1};
        c1 = (n1 > 8) ? 8 : n1;
        c2 = (n2 > 32) ? 32 : n2;
        c3 = (n3 > 256) ? 256 : n3;
        exp_err = (n1 > 8) || (n2 > 32) || (n3 > 256);
        exp_q.delete(); exp1.delete(); exp2.delete(); exp3.delete();
        for (int i = 0; i <= c1 + c2 + c3; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
        for (int k = 0; k < c1; k++) exp1.push_back(get_word(32'h1004 + 32'(4 * k)) & 32'h7f);
        for (int k = 0; k < c2; k++) exp2.push_back(get_word(32'h1004 + 32'(4 * (c1 + k))) & 32'h3ff);
        for (int k = 0; k < c3; k++) exp3.push_back(get_word(32'h1004 + 32'(4 * (c1 + c2 + k))) & 32'h7fff);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk); #1;
        resetn = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        fetch_q.delete(); got1.delete(); got2.delete(); got3.delete();
        done_cyc = -1; last_xfer_cyc = -1; last_wr_cyc = -1; xfer_age = 0;
        @(negedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic run_check(input string tag);
        int budget, n;
        budget = 10 * (exp_q.size() + 2);
        n = 0;
        while (!boot_done && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, " boot_done within budget"}, 32'(boot_done), 32'd1);
        check({tag, " fetch count"}, 32'(fetch_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s fetch[%0d]", tag, i), fetch_q[i], exp_q[i]);
        check({tag, " dict1 count"}, 32'(got1.size()), 32'(exp1.size()));
        for (int k = 0; k < exp1.size(); k++)
            check($sformatf("%s dict1[%0d]", tag, k), 32'(got1[k]), 32'(exp1[k]));
        check({tag, " dict2 count"}, 32'(got2.size()), 32'(exp2.size()));
        for (int k = 0; k < exp2.size(); k++)
            check($sformatf("%s dict2[%0d]", tag, k), 32'(got2[k]), 32'(exp2[k]));
        check({tag, " dict3 count"}, 32'(got3.size()), 32'(exp3.size()));
        for (int k = 0; k < exp3.size(); k++)
            check($sformatf("%s dict3[%0d]", tag, k), 32'(got3[k]), 32'(exp3[k]));
        check({tag, " boot_err"}, 32'(boot_err), 32'(exp_err));
        check({tag, " done one cycle after last fetch"}, 32'(done_cyc), 32'(last_xfer_cyc + 1));
        if (exp_q.size() > 1)
            check({tag, " last write with done"}, 32'(last_wr_cyc), 32'(done_cyc));
        else
            check({tag, " no writes"}, 32'(last_wr_cyc), 32'hffff_ffff);
        check({tag, " passthru valid"}, 32'(mem_req_valid), 32'd1);
        check({tag, " passthru addr"}, mem_req_addr, 32'h80);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0;
        ctrl_req_valid = 1'b1;
        ctrl_req_addr  = 32'h80;
        nl_ctrl_valid  = 1'b0;
        nl_ctrl_addr   = 32'h0;
        nl_mem_ready   = 1'b0;
        nl_mem_rdata   = 32'h0;
        setup_image(2, 1, 1);

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst mem_req_addr", mem_req_addr, 32'h1000);
        check("rst write enables", {29'd0, d1_we, d2_we, d3_we}, 32'd0);
        check("rst write vals", {d1_val, d2_val, d3_val}, 32'd0);
        check("rst boot_done", 32'(boot_done), 32'd0);
        check("rst boot_err", 32'(boot_err), 32'd0);
        check("rst ctrl_req_ready", 32'(ctrl_req_ready), 32'd0);
        check("rst ctrl_req_rdata", ctrl_req_rdata, 32'd0);
        check("rst state", 32'(state_dbg), 32'(ST_HDR));
        check("rst nl boot_done", 32'(nl_boot_done), 32'd0);
        resetn = 1'b1;
        @(negedge clk); #1;
        check("nl boot_done one cycle after release", 32'(nl_boot_done), 32'd1);
        check("nl state", 32'(nl_state_dbg), 32'(ST_DONE));
        run_check("hdr_2_1_1");

        n = 0;
        while (ctrl_req_ready !== 1'b1 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        check("passthru ready", 32'(ctrl_req_ready), 32'd1);
        check("passthru rdata", ctrl_req_rdata, get_word(32'h80));

        setup_image(0, 0, 0);
        apply_reset(2);
        run_check("hdr_zero");

        setup_image(9, 0, 0);
        apply_reset(2);
        run_check("hdr_9_0_0");

        lat_min = 0; lat_max = 2;
        setup_image(1, 33, 0);
        apply_reset(2);
        run_check("hdr_1_33_0");

        setup_image(3, 4, 2);
        apply_reset(2);
        n = 0;
        while (got2.size() < 1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("midload reached LOAD2", 32'(got2.size() >= 1), 32'd1);
        apply_reset(1);
        run_check("midload_reset");

        for (int t = 0; t < 6; t++) begin
            setup_image($urandom_range(10, 0), $urandom_range(34, 0), $urandom_range(40, 0));
            apply_reset(2);
            run_check($sformatf("rand%0d", t));
        end

        lat_min = 0; lat_max = 0;
        setup_image(8, 32, 255);
        apply_reset(2);
        run_check("hdr_full");

        repeat (4) @(negedge clk);
        #1;
        check("valid gap exactly one cycle", 32'(viol_gap), 32'd0);
        check("ctrl quiet before done", 32'(viol_ctrl), 32'd0);
        check("single write enable", 32'(viol_onehot), 32'd0);
        check("nl never drives mem_req_valid", 32'(viol_nl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
